// File: rtl/multdiv_wb_unit_if.sv
// Operand/start and result/write-back bundle between the execute stage and the
// multiply/divide unit.
interface multdiv_wb_unit_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_destReg;
    logic        busy;
    logic        data_resultRDY;
    logic [31:0] data_result;
    logic        data_exception;
    logic        wb_writeEnable;
    logic [4:0]  wb_writeReg;
    logic [31:0] wb_data;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_destReg,
        input  busy, data_resultRDY, data_result, data_exception,
               wb_writeEnable, wb_writeReg, wb_data
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_destReg,
        output busy, data_resultRDY, data_result, data_exception,
               wb_writeEnable, wb_writeReg, wb_data
    );
endinterface

// File: rtl/multdiv_wb_unit.sv
// 32-cycle signed multiply (radix-2 Booth) / divide (non-restoring) with regfile write-back.
// Optional macro MULTDIV_RSTATUS_EN redirects exception write-backs to r30 as a status code.
module multdiv_wb_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic               clock,
    input logic               ctrl_reset,
    multdiv_wb_unit_if.slave  bus
);
    // state  | meaning
    // S_IDLE | waiting for a single start pulse
    // S_RUN  | one Booth / non-restoring step per cycle, 32 cycles
    // S_DONE | result registered, write-back strobe valid
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH+1:0]   acc_q;
    logic [WIDTH-1:0]   q_q, m_q;
    logic               qm1_q, div_q, neg_q, dz_q, dovf_q;
    logic [4:0]         dest_q;
    logic [WIDTH-1:0]   result_q, wdata_q;
    logic               exc_q, rdy_q, we_q;
    logic [4:0]         wreg_q;

    logic               start_mul, start_div, load, step, finish;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH+1:0]   mul_sum, div_sh, div_rem, acc_step;
    logic [WIDTH-1:0]   q_step, quot, fin_res, fin_wdata;
    logic               qm1_step, mul_ovf, fin_exc, fin_we;
    logic [4:0]         fin_wreg;
    logic [2*WIDTH-1:0] prod;

    assign start_mul = bus.ctrl_MULT & ~bus.ctrl_DIV;
    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign a_mag = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1)) : bus.data_operandA;
    assign b_mag = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1)) : bus.data_operandB;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_mul | start_div) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One iteration of whichever algorithm is loaded; the final result is taken
    // from this step's output so it can be registered on the last RUN edge.
    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   mul_sum = acc_q + {{2{m_q[WIDTH-1]}}, m_q};
            2'b10:   mul_sum = acc_q - {{2{m_q[WIDTH-1]}}, m_q};
            default: mul_sum = acc_q;
        endcase
        div_sh  = {acc_q[WIDTH:0], q_q[WIDTH-1]};
        div_rem = acc_q[WIDTH+1] ? (div_sh + {2'b00, m_q}) : (div_sh - {2'b00, m_q});
        if (div_q) begin
            acc_step = div_rem;
            q_step   = {q_q[WIDTH-2:0], ~div_rem[WIDTH+1]};
            qm1_step = 1'b0;
        end else begin
            acc_step = {mul_sum[WIDTH+1], mul_sum[WIDTH+1:1]};
            q_step   = {mul_sum[0], q_q[WIDTH-1:1]};
            qm1_step = q_q[0];
        end
    end

    always_comb begin
        prod    = {acc_step[WIDTH-1:0], q_step};
        mul_ovf = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
        quot    = neg_q ? (~q_step + WIDTH'(1)) : q_step;
        if (div_q) begin
            fin_res = dz_q ? '0 : quot;
            fin_exc = dz_q | dovf_q;
        end else begin
            fin_res = q_step;
            fin_exc = mul_ovf;
        end
        fin_we    = (dest_q != 5'd0);
        fin_wreg  = dest_q;
        fin_wdata = fin_res;
`ifdef MULTDIV_RSTATUS_EN
        if (fin_exc) begin
            fin_we    = 1'b1;
            fin_wreg  = 5'd30;
            fin_wdata = div_q ? WIDTH'(5) : WIDTH'(4);
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            qm1_q    <= 1'b0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            dovf_q   <= 1'b0;
            dest_q   <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= finish;
            we_q    <= finish & fin_we;
            if (load) begin
                acc_q  <= '0;
                qm1_q  <= 1'b0;
                div_q  <= start_div;
                dest_q <= bus.ctrl_destReg;
                q_q    <= start_div ? a_mag : bus.data_operandB;
                m_q    <= start_div ? b_mag : bus.data_operandA;
                neg_q  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                dz_q   <= (bus.data_operandB == '0);
                dovf_q <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                          (bus.data_operandB == {WIDTH{1'b1}});
            end else if (step) begin
                acc_q <= acc_step;
                q_q   <= q_step;
                qm1_q <= qm1_step;
            end
            if (finish) begin
                result_q <= fin_res;
                exc_q    <= fin_exc;
                wreg_q   <= fin_wreg;
                wdata_q  <= fin_wdata;
            end
        end
    end

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.wb_writeEnable = we_q;
    assign bus.wb_writeReg    = wreg_q;
    assign bus.wb_data        = wdata_q;
endmodule

// File: tb/tb_multdiv_wb_unit.sv
// Directed bench for multdiv_wb_unit: expected results queued at start, checked at resultRDY.
module tb_multdiv_wb_unit;
    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } exp_t;

    logic clock;
    logic ctrl_reset;
    int   checks = 0;
    int   failures = 0;
    int   accepted = 0;
    int   rdy_count = 0;
    logic [31:0] last_res = '0;
    exp_t sb[$];

    multdiv_wb_unit_if bus ();

    multdiv_wb_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] dest);
        exp_t        e;
        int          ai;
        int          bi;
        longint      p;
        logic [63:0] pu;
        ai = a;
        bi = b;
        if (!is_div) begin
            p     = longint'(ai) * longint'(bi);
            pu    = p;
            e.res = pu[31:0];
            e.exc = !((pu[63:31] == {33{1'b1}}) || (pu[63:31] == 33'd0));
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            e.res = ai / bi;
            e.exc = 1'b0;
        end
        e.we    = (dest != 5'd0);
        e.wreg  = dest;
        e.wdata = e.res;
`ifdef MULTDIV_RSTATUS_EN
        if (e.exc) begin
            e.we    = 1'b1;
            e.wreg  = 5'd30;
            e.wdata = is_div ? 32'd5 : 32'd4;
        end
`endif
        return e;
    endfunction

    // Scoreboard consumer: every resultRDY pops one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) begin
                rdy_count++;
                chk("rdy_has_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("data_result", bus.data_result, e.res);
                    chk("data_exception", 32'(bus.data_exception), 32'(e.exc));
                    chk("wb_writeEnable", 32'(bus.wb_writeEnable), 32'(e.we));
                    if (e.we) begin
                        chk("wb_writeReg", 32'(bus.wb_writeReg), 32'(e.wreg));
                        chk("wb_data", bus.wb_data, e.wdata);
                    end
                end
            end else begin
                chk("we_without_rdy", 32'(bus.wb_writeEnable), 32'd0);
            end
        end
    end

    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dest, input int s1, input int s2);
        exp_t e;
        int   rdy_k;
        bit   stray;
        rdy_k = -1;
        @(negedge clock);
        bus.ctrl_MULT     = !is_div;
        bus.ctrl_DIV      = is_div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_destReg  = dest;
        e = model(is_div, a, b, dest);
        sb.push_back(e);
        accepted++;
        last_res = e.res;
        for (int k = 0; k <= 34; k++) begin
            @(negedge clock);
            stray             = (k == s1) || (k == s2);
            bus.ctrl_MULT     = stray && is_div;
            bus.ctrl_DIV      = stray && !is_div;
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
            bus.ctrl_destReg  = 5'($urandom);
            if (bus.data_resultRDY === 1'b1 && rdy_k < 0) rdy_k = k;
            if (k == 0 || k == 16 || k == 32 || k == 33 || k == s1 + 1 || k == s2 + 1)
                chk($sformatf("busy_k%0d", k), 32'(bus.busy), 32'(k <= 32));
        end
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        chk("rdy_latency", 32'(rdy_k), 32'd32);
    endtask

    initial begin
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_destReg  = '0;
        ctrl_reset        = 1'b1;
        repeat (3) @(negedge clock);
        ctrl_reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
        chk("rst_result", bus.data_result, 32'd0);
        chk("rst_exc", 32'(bus.data_exception), 32'd0);
        chk("rst_wreg", 32'(bus.wb_writeReg), 32'd0);
        chk("rst_wdata", bus.wb_data, 32'd0);

        run_op(1'b0, 32'd7, -32'sd6, 5'd3, -1, -1);
        run_op(1'b1, -32'sd100, 32'd7, 5'd4, 5, 20);
        run_op(1'b1, 32'd5, 32'd0, 5'd5, 32, -1);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd6, -1, -1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, -1, -1);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd8, -1, -1);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, -1, -1);
        run_op(1'b1, 32'h8000_0000, 32'd1, 5'd10, -1, -1);
        run_op(1'b1, 32'd7, -32'sd2, 5'd11, -1, -1);
        run_op(1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0, -1, -1);

        // Abort a multiply with reset; nothing must ever be reported for it.
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd12;
        bus.data_operandB = 32'd12;
        bus.ctrl_destReg  = 5'd12;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        repeat (9) @(negedge clock);
        chk("busy_before_abort", 32'(bus.busy), 32'd1);
        ctrl_reset = 1'b1;
        @(negedge clock);
        ctrl_reset = 1'b0;
        chk("busy_after_abort", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clock);
        chk("busy_abort_idle", 32'(bus.busy), 32'd0);
        chk("result_cleared", bus.data_result, 32'd0);

        run_op(1'b1, 32'd9, 32'd3, 5'd0, -1, -1);

        // MULT and DIV together in IDLE is not a start.
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.ctrl_DIV  = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("busy_both_start", 32'(bus.busy), 32'd0);
            @(negedge clock);
        end

        for (int i = 0; i < 4; i++)
            run_op(1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(1, 70000)),
                   5'($urandom_range(1, 31)), -1, -1);

        repeat (5) @(negedge clock);
        chk("result_hold", bus.data_result, last_res);
        chk("rdy_count", 32'(rdy_count), 32'(accepted));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
